// File: rtl/priority_queue.sv
// ----------------------------------------------------------------------------
// priority_queue
//   Distance store and minimum finder for the Dijkstra shortest-path engine.
//   Each graph node has one VALUE_WIDTH distance. Any entry can be read
//   combinationally or written synchronously by node index. The smallest
//   distance among unvisited nodes, and that node's index, is reported from
//   registers.
//
// Optional feature (compile-time macro PRIORITY_QUEUE_MIN_VALID_EN):
//   Adds min_valid, a registered flag with the same timing as min_value. It is
//   high when at least one unvisited entry holds a value other than INFINITY.
//
// Ports
//   clock          in   system clock, rising edge
//   reset          in   asynchronous active-low reset
//   set_en         in   write enable (only a clean logic 1 writes)
//   index          in   node selected for read and write
//   visited_vector in   bit i set = node i excluded from the minimum
//   write_value    in   distance written to dist[index]
//   read_value     out  dist[index], combinational (INFINITY if out of range)
//   min_index      out  index of smallest unvisited distance, registered
//   min_value      out  smallest unvisited distance, registered
//   min_valid      out  (optional) some unvisited node is reachable
// ----------------------------------------------------------------------------
module priority_queue #(
  parameter int MAX_NODES   = 8,
  parameter int INDEX_WIDTH = 8,
  parameter int VALUE_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   set_en,
  input  logic [INDEX_WIDTH-1:0] index,
  input  logic [MAX_NODES-1:0]   visited_vector,
  input  logic [VALUE_WIDTH-1:0] write_value,
  output logic [VALUE_WIDTH-1:0] read_value,
  output logic [INDEX_WIDTH-1:0] min_index,
`ifdef PRIORITY_QUEUE_MIN_VALID_EN
  output logic [VALUE_WIDTH-1:0] min_value,
  output logic                   min_valid
`else
  output logic [VALUE_WIDTH-1:0] min_value
`endif
);

  localparam logic [VALUE_WIDTH-1:0] INFINITY = '1;

  logic [VALUE_WIDTH-1:0] dist_q [MAX_NODES];
  logic [VALUE_WIDTH-1:0] dist_d [MAX_NODES];
  logic [VALUE_WIDTH-1:0] min_value_q, min_value_d;
  logic [INDEX_WIDTH-1:0] min_index_q, min_index_d;
  logic                   min_valid_q, min_valid_d;
  logic [MAX_NODES-1:0]   index_hit;
  logic                   wr_en;
  logic                   found;

  // One-hot decode of index; an out-of-range index matches no entry, so it
  // reads INFINITY and writes nothing.
  always_comb begin
    for (int i = 0; i < MAX_NODES; i++) begin
      index_hit[i] = (index == INDEX_WIDTH'(i));
    end
  end

  // NOTE: an if() on an X or Z condition takes the else path in simulation,
  // so X/Z on set_en resolves to "no write" instead of smearing X into the
  // array the way a ?: select would.
  always_comb begin
    wr_en = 1'b0;
    if (set_en) wr_en = 1'b1;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; that is what keeps these blocks from inferring latches.
  always_comb begin
    for (int i = 0; i < MAX_NODES; i++) begin
      dist_d[i] = dist_q[i];
      if (wr_en && index_hit[i]) dist_d[i] = write_value;
    end
  end

  always_comb begin
    read_value = INFINITY;
    for (int i = 0; i < MAX_NODES; i++) begin
      if (index_hit[i]) read_value = dist_q[i];
    end
  end

  // Linear scan over the pre-write array. The strict '<' keeps the first
  // (lowest-index) occurrence on ties; 'found' makes the first unvisited node
  // win even when every candidate is INFINITY.
  always_comb begin
    min_value_d = INFINITY;
    min_index_d = '0;
    found       = 1'b0;
    for (int i = 0; i < MAX_NODES; i++) begin
      if (!visited_vector[i] && (!found || dist_q[i] < min_value_d)) begin
        min_value_d = dist_q[i];
        min_index_d = INDEX_WIDTH'(i);
        found       = 1'b1;
      end
    end
    min_valid_d = (min_value_d != INFINITY);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values. The distance array is reset explicitly because
  // the source node must start at 0 and every other node at INFINITY.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_NODES; i++) begin
        dist_q[i] <= (i == 0) ? '0 : INFINITY;
      end
      min_value_q <= '0;
      min_index_q <= '0;
      min_valid_q <= 1'b1;
    end else begin
      dist_q      <= dist_d;
      min_value_q <= min_value_d;
      min_index_q <= min_index_d;
      min_valid_q <= min_valid_d;
    end
  end

  assign min_value = min_value_q;
  assign min_index = min_index_q;

`ifdef PRIORITY_QUEUE_MIN_VALID_EN
  assign min_valid = min_valid_q;
`else
  logic unused_valid;
  assign unused_valid = min_valid_q;
`endif

endmodule

// File: tb/tb_priority_queue.sv
// ----------------------------------------------------------------------------
// tb_priority_queue
//   Directed self-checking bench for priority_queue (8 nodes, 8-bit values).
//   Inputs are driven at the falling edge and outputs are sampled at the
//   falling edge, half a cycle away from the active rising edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_priority_queue;

  logic       clock;
  logic       reset;
  logic       set_en;
  logic [7:0] index;
  logic [7:0] visited_vector;
  logic [7:0] write_value;
  logic [7:0] read_value;
  logic [7:0] min_index;
  logic [7:0] min_value;
`ifdef PRIORITY_QUEUE_MIN_VALID_EN
  logic       min_valid;
`endif

  int total;
  int bad;

  priority_queue #(.MAX_NODES(8), .INDEX_WIDTH(8), .VALUE_WIDTH(8)) dut (
    .clock          (clock),
    .reset          (reset),
    .set_en         (set_en),
    .index          (index),
    .visited_vector (visited_vector),
    .write_value    (write_value),
    .read_value     (read_value),
    .min_index      (min_index),
`ifdef PRIORITY_QUEUE_MIN_VALID_EN
    .min_value      (min_value),
    .min_valid      (min_valid)
`else
    .min_value      (min_value)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and return at the following falling edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Single-edge write, then release the enable to Z.
  task automatic write_entry(input logic [7:0] idx, input logic [7:0] val);
    set_en      = 1'b1;
    index       = idx;
    write_value = val;
    tick();
    set_en      = 1'bz;
  endtask

  task automatic test_reset();
    logic [7:0] exp_rd;
    reset = 1'b0;
    set_en = 1'bz;
    index = 8'd0;
    write_value = 8'd0;
    visited_vector = 8'h00;
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      index = 8'(i);
      exp_rd = (i == 0) ? 8'd0 : 8'd255;
      #1;
      total++;
      if (read_value !== exp_rd) begin
        bad++;
        $display("FAIL reset_read[%0d] got=%0d exp=%0d", i, read_value, exp_rd);
      end
    end
    total++;
    if (min_value !== 8'd0 || min_index !== 8'd0) begin
      bad++;
      $display("FAIL reset_min got=%0d@%0d exp=0@0", min_value, min_index);
    end
`ifdef PRIORITY_QUEUE_MIN_VALID_EN
    total++;
    if (min_valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_valid got=%b exp=1", min_valid);
    end
`endif
    @(negedge clock);
  endtask

  task automatic test_source_overwrite();
    set_en = 1'b1;
    index = 8'd0;
    write_value = 8'd255;
    tick();
    // Min register sampled the pre-write array on this edge: still 0.
    total++;
    if (min_value !== 8'd0 || min_index !== 8'd0) begin
      bad++;
      $display("FAIL overwrite_latency got=%0d@%0d exp=0@0", min_value, min_index);
    end
    tick();
    set_en = 1'bz;
    #1;
    total++;
    if (min_value !== 8'd255 || min_index !== 8'd0 || read_value !== 8'd255) begin
      bad++;
      $display("FAIL overwrite_min got=%0d@%0d rd=%0d exp=255@0 rd=255",
               min_value, min_index, read_value);
    end
`ifdef PRIORITY_QUEUE_MIN_VALID_EN
    total++;
    if (min_valid !== 1'b0) begin
      bad++;
      $display("FAIL overwrite_valid got=%b exp=0", min_valid);
    end
`endif
  endtask

  task automatic test_fill();
    logic [7:0] vals    [8];
    logic [7:0] exp_min [8];
    logic [7:0] exp_idx [8];
    vals    = '{8'd23, 8'd41, 8'd7, 8'd30, 8'd7, 8'd12, 8'd49, 8'd3};
    // Running minimum after each write (other entries still 255).
    exp_min = '{8'd23, 8'd23, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd3};
    exp_idx = '{8'd0,  8'd0,  8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd7};
    for (int i = 0; i < 8; i++) begin
      write_entry(8'(i), vals[i]);
      total++;
      if (read_value !== vals[i]) begin
        bad++;
        $display("FAIL fill_read[%0d] got=%0d exp=%0d", i, read_value, vals[i]);
      end
      tick();
      total++;
      if (min_value !== exp_min[i] || min_index !== exp_idx[i]) begin
        bad++;
        $display("FAIL fill_min[%0d] got=%0d@%0d exp=%0d@%0d",
                 i, min_value, min_index, exp_min[i], exp_idx[i]);
      end
    end
  endtask

  task automatic test_visited_mask();
    write_entry(8'd0, 8'd5);
    write_entry(8'd1, 8'd3);
    write_entry(8'd2, 8'd3);
    write_entry(8'd3, 8'd9);
    for (int i = 4; i < 8; i++) write_entry(8'(i), 8'd255);
    tick();
    total++;
    if (min_value !== 8'd3 || min_index !== 8'd1) begin
      bad++;
      $display("FAIL mask_tie got=%0d@%0d exp=3@1", min_value, min_index);
    end
    visited_vector = 8'b0000_0010;
    tick();
    total++;
    if (min_value !== 8'd3 || min_index !== 8'd2) begin
      bad++;
      $display("FAIL mask_skip1 got=%0d@%0d exp=3@2", min_value, min_index);
    end
    // Only INFINITY entries remain unvisited: lowest unvisited index wins.
    visited_vector = 8'b0000_1111;
    tick();
    total++;
    if (min_value !== 8'd255 || min_index !== 8'd4) begin
      bad++;
      $display("FAIL mask_all_inf got=%0d@%0d exp=255@4", min_value, min_index);
    end
`ifdef PRIORITY_QUEUE_MIN_VALID_EN
    total++;
    if (min_valid !== 1'b0) begin
      bad++;
      $display("FAIL mask_all_inf_valid got=%b exp=0", min_valid);
    end
`endif
    visited_vector = 8'hff;
    tick();
    total++;
    if (min_value !== 8'd255 || min_index !== 8'd0) begin
      bad++;
      $display("FAIL mask_all_visited got=%0d@%0d exp=255@0", min_value, min_index);
    end
    visited_vector = 8'h00;
    tick();
    total++;
    if (min_value !== 8'd3 || min_index !== 8'd1) begin
      bad++;
      $display("FAIL mask_clear got=%0d@%0d exp=3@1", min_value, min_index);
    end
`ifdef PRIORITY_QUEUE_MIN_VALID_EN
    total++;
    if (min_valid !== 1'b1) begin
      bad++;
      $display("FAIL mask_clear_valid got=%b exp=1", min_valid);
    end
`endif
  endtask

  task automatic test_enable_and_range();
    index = 8'd0;
    write_value = 8'd77;
    set_en = 1'bz;
    tick();
    total++;
    if (read_value !== 8'd5) begin
      bad++;
      $display("FAIL en_z got=%0d exp=5", read_value);
    end
    set_en = 1'bx;
    write_value = 8'd1;
    tick();
    total++;
    if (read_value !== 8'd5) begin
      bad++;
      $display("FAIL en_x got=%0d exp=5", read_value);
    end
    set_en = 1'b0;
    tick();
    total++;
    if (read_value !== 8'd5) begin
      bad++;
      $display("FAIL en_0 got=%0d exp=5", read_value);
    end
    // Index 9 aliases node 1 if the decode truncated; node 1 must keep 3.
    set_en = 1'b1;
    index = 8'd9;
    write_value = 8'd0;
    tick();
    set_en = 1'bz;
    #1;
    total++;
    if (read_value !== 8'd255) begin
      bad++;
      $display("FAIL oor_read got=%0d exp=255", read_value);
    end
    index = 8'd1;
    #1;
    total++;
    if (read_value !== 8'd3) begin
      bad++;
      $display("FAIL oor_alias got=%0d exp=3", read_value);
    end
    tick();
    total++;
    if (min_value !== 8'd3 || min_index !== 8'd1) begin
      bad++;
      $display("FAIL oor_min got=%0d@%0d exp=3@1", min_value, min_index);
    end
  endtask

  task automatic test_async_reset();
    write_entry(8'd3, 8'd1);
    tick();
    total++;
    if (min_value !== 8'd1 || min_index !== 8'd3) begin
      bad++;
      $display("FAIL pre_reset_min got=%0d@%0d exp=1@3", min_value, min_index);
    end
    // Start another write, then pull reset between edges.
    set_en = 1'b1;
    index = 8'd2;
    write_value = 8'd0;
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (min_value !== 8'd0 || min_index !== 8'd0 || read_value !== 8'd255) begin
      bad++;
      $display("FAIL async_reset got=%0d@%0d rd=%0d exp=0@0 rd=255",
               min_value, min_index, read_value);
    end
    index = 8'd3;
    #1;
    total++;
    if (read_value !== 8'd255) begin
      bad++;
      $display("FAIL async_reset_entry3 got=%0d exp=255", read_value);
    end
    // Writes are ignored while reset is held across an edge.
    index = 8'd2;
    tick();
    total++;
    if (read_value !== 8'd255 || min_value !== 8'd0) begin
      bad++;
      $display("FAIL reset_hold rd=%0d min=%0d exp rd=255 min=0", read_value, min_value);
    end
    set_en = 1'bz;
    reset = 1'b1;
    tick();
    total++;
    if (min_value !== 8'd0 || min_index !== 8'd0) begin
      bad++;
      $display("FAIL post_reset_min got=%0d@%0d exp=0@0", min_value, min_index);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_source_overwrite();
    test_fill();
    test_visited_mask();
    test_enable_and_range();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
